mdu_div_seq: RTL and testbench

Parametrised sequential integer divider for the multiply/divide unit (MDU). It accepts one signed or unsigned WIDTH-bit division through a valid/ready handshake and returns quotient and remainder together with a one-cycle done pulse. RISC-V semantics apply: division by zero and signed overflow use a single-cycle fast path. The block replaces fixed-32-bit dividers and is instanced once per MDU.

---
 rtl/mdu_div_seq_if.sv | 23 ++
 rtl/mdu_div_seq.sv | 101 ++++++++++
 tb/tb_mdu_div_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mdu_div_seq_if.sv
// Request/response bundle between an MDU issue stage and the sequential divider.
interface mdu_div_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_div_sign;
  logic             i_div_valid;
  logic             o_div_ready;
  logic [WIDTH-1:0] o_div_rd;
  logic [WIDTH-1:0] o_rem_rd;
  logic             o_div_done;

  modport master (
    output i_dividend, i_divisor, i_div_sign, i_div_valid,
    input  o_div_ready, o_div_rd, o_rem_rd, o_div_done
  );

  modport slave (
    input  i_dividend, i_divisor, i_div_sign, i_div_valid,
    output o_div_ready, o_div_rd, o_rem_rd, o_div_done
  );
endinterface

// File: rtl/mdu_div_seq.sv
// Sequential restoring divider (signed/unsigned) with RISC-V divide-by-zero and
// overflow fast paths; quotient and remainder delivered with a one-cycle done pulse.
//
// state | meaning
// IDLE  | ready, waiting for a request
// CALC  | one restoring step per cycle, WIDTH steps
// FIX   | apply result signs, register outputs
// DONE  | done pulse, outputs valid
module mdu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mdu_div_seq_if.slave      bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_p;
  logic [WIDTH-1:0] quo, dvs, q_out, r_out;
  logic             neg_q, neg_r;
  logic             ready, done, accept, div_zero, ovf;
  logic [WIDTH+1:0] shifted, trial;

  assign div_zero = (bus.i_divisor == '0);
  assign ovf      = bus.i_div_sign && (bus.i_dividend == MIN_NEG) && (&bus.i_divisor);
  assign accept   = bus.i_div_valid && ready;

  // Remainder is kept below the divisor, so the extra top bit only guards the trial sign.
  assign shifted  = {rem_p, quo[WIDTH-1]};
  assign trial    = shifted - {2'b00, dvs};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = (state == IDLE) && !i_rst;
    done      = (state == DONE);
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      rem_p <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q_out <= '0;
      r_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (div_zero) begin
            q_out <= '1;
            r_out <= bus.i_dividend;
          end else if (ovf) begin
            q_out <= bus.i_dividend;
            r_out <= '0;
          end else begin
            quo   <= (bus.i_div_sign && bus.i_dividend[WIDTH-1]) ? -bus.i_dividend : bus.i_dividend;
            dvs   <= (bus.i_div_sign && bus.i_divisor[WIDTH-1])  ? -bus.i_divisor  : bus.i_divisor;
            neg_q <= bus.i_div_sign && (bus.i_dividend[WIDTH-1] != bus.i_divisor[WIDTH-1]);
            neg_r <= bus.i_div_sign && bus.i_dividend[WIDTH-1];
            rem_p <= '0;
            cnt   <= CW'(WIDTH-1);
          end
        end
        CALC: begin
          rem_p <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          quo   <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          q_out <= neg_q ? -quo : quo;
          r_out <= neg_r ? -rem_p[WIDTH-1:0] : rem_p[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.o_div_ready = ready;
  assign bus.o_div_done  = done;
  assign bus.o_div_rd    = q_out;
  assign bus.o_rem_rd    = r_out;
endmodule

// File: tb/tb_mdu_div_seq.sv
// Directed bench for mdu_div_seq: a 32-bit and an 8-bit instance checked against hand-computed results.
module tb_mdu_div_seq;
  logic clk = 1'b0;
  logic rst32, rst8;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mdu_div_seq_if #(.WIDTH(32)) b32 ();
  mdu_div_seq_if #(.WIDTH(8))  b8  ();

  mdu_div_seq #(.WIDTH(32)) u_div32 (.i_clk(clk), .i_rst(rst32), .bus(b32));
  mdu_div_seq #(.WIDTH(8))  u_div8  (.i_clk(clk), .i_rst(rst8),  .bus(b8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output int lat, output int wait_c, output bit rdy_seen);
    wait_c = 0;
    while (!b32.o_div_ready && wait_c < 100) begin
      @(posedge clk); #1; wait_c++;
    end
    b32.i_dividend = a; b32.i_divisor = b; b32.i_div_sign = s; b32.i_div_valid = 1'b1;
    @(posedge clk); #1;
    b32.i_div_valid = 1'b0;
    b32.i_dividend = $urandom; b32.i_divisor = $urandom; b32.i_div_sign = ~s;
    lat = 1; rdy_seen = 1'b0;
    while (!b32.o_div_done && lat < 100) begin
      if (b32.o_div_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    q = b32.o_div_rd; r = b32.o_rem_rd;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [7:0] q, output logic [7:0] r,
                      output int lat, output int wait_c);
    wait_c = 0;
    while (!b8.o_div_ready && wait_c < 100) begin
      @(posedge clk); #1; wait_c++;
    end
    b8.i_dividend = a; b8.i_divisor = b; b8.i_div_sign = s; b8.i_div_valid = 1'b1;
    @(posedge clk); #1;
    b8.i_div_valid = 1'b0;
    b8.i_dividend = 8'hA5; b8.i_divisor = 8'h00; b8.i_div_sign = ~s;
    lat = 1;
    while (!b8.o_div_done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    q = b8.o_div_rd; r = b8.o_rem_rd;
  endtask

  initial begin
    logic [31:0] q, r;
    logic [7:0]  q8, r8;
    int          lat, wc, pulses;
    bit          rs;

    rst32 = 1'b1; rst8 = 1'b1;
    b32.i_dividend = '0; b32.i_divisor = '0; b32.i_div_sign = 1'b0; b32.i_div_valid = 1'b0;
    b8.i_dividend  = '0; b8.i_divisor  = '0; b8.i_div_sign  = 1'b0; b8.i_div_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", b32.o_div_ready, 0);
    chk("rst_done", b32.o_div_done, 0);
    chk("rst_q", b32.o_div_rd, 0);
    chk("rst_r", b32.o_rem_rd, 0);
    rst32 = 1'b0; rst8 = 1'b0;
    #1;
    chk("rst_ready_high", b32.o_div_ready, 1);

    run32(32'd100, 32'd7, 1'b0, q, r, lat, wc, rs);
    chk("u100_7_q", q, 14);
    chk("u100_7_r", r, 2);
    chk("u100_7_lat", lat, 34);
    chk("u100_7_ready_busy", rs, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", b32.o_div_rd, 14);
    chk("no_extra_done", b32.o_div_done, 0);

    run32(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat, wc, rs);
    chk("sm7_2_q", q, 32'hFFFF_FFFD);
    chk("sm7_2_r", r, 32'hFFFF_FFFF);

    run32(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, lat, wc, rs);
    chk("s7_m2_q", q, 32'hFFFF_FFFD);
    chk("s7_m2_r", r, 32'h1);

    run32(32'h1234, 32'h0, 1'b1, q, r, lat, wc, rs);
    chk("sdz_q", q, 32'hFFFF_FFFF);
    chk("sdz_r", r, 32'h1234);
    chk("sdz_lat", lat, 1);

    run32(32'h1234, 32'h0, 1'b0, q, r, lat, wc, rs);
    chk("udz_q", q, 32'hFFFF_FFFF);
    chk("udz_r", r, 32'h1234);
    chk("udz_lat", lat, 1);

    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, wc, rs);
    chk("sovf_q", q, 32'h8000_0000);
    chk("sovf_r", r, 0);
    chk("sovf_lat", lat, 1);

    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, lat, wc, rs);
    chk("uovf_q", q, 0);
    chk("uovf_r", r, 32'h8000_0000);
    chk("uovf_lat", lat, 34);

    // abort on the 10th CALC cycle
    @(posedge clk); #1;
    b32.i_dividend = 32'd1000; b32.i_divisor = 32'd3; b32.i_div_sign = 1'b0; b32.i_div_valid = 1'b1;
    @(posedge clk); #1;
    b32.i_div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst32 = 1'b1;
    #1;
    chk("abort_ready_in_rst", b32.o_div_ready, 0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    #1;
    chk("abort_ready", b32.o_div_ready, 1);
    chk("abort_q", b32.o_div_rd, 0);
    chk("abort_r", b32.o_rem_rd, 0);
    pulses = 0;
    repeat (40) begin
      if (b32.o_div_done) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", pulses, 0);

    run32(32'd200, 32'd10, 1'b0, q, r, lat, wc, rs);
    chk("u200_10_q", q, 20);
    chk("u200_10_r", r, 0);

    run8(8'hF0, 8'h03, 1'b0, q8, r8, lat, wc);
    chk("w8_f0_3_q", q8, 8'h50);
    chk("w8_f0_3_r", r8, 8'h00);
    chk("w8_lat", lat, 10);

    run8(8'h7F, 8'h05, 1'b0, q8, r8, lat, wc);
    chk("w8_b2b_wait", wc, 1);
    chk("w8_b2b_q", q8, 8'h19);
    chk("w8_b2b_r", r8, 8'h02);

    run8(8'h80, 8'h03, 1'b1, q8, r8, lat, wc);
    chk("w8_s_q", q8, 8'hD6);
    chk("w8_s_r", r8, 8'hFE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
